led_matrix_read_arbiter: RTL

Shares one external pixel-memory read-request port among NUM_PORTS `led_matrix_controller` instances, one per panel row. Selects a requester round-robin, forwards its read addresses to the memory FIFO, and records the requester index of every issued read in an in-order tag queue. Each returned word is routed back to the requester that issued it. It sits between the controllers' `address_fifo`/`data_out_ready_fifo`/`fifo_full`/`data_in_*` ports and the SDRAM read FIFO.

---
 rtl/led_matrix_read_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/led_matrix_read_arbiter.sv
`default_nettype none
// led_matrix_read_arbiter: round-robin sharing of one pixel-memory read port among
// NUM_PORTS panel controllers, with an in-order tag queue routing returned words.
module led_matrix_read_arbiter #(
  parameter int ADDRESS_WIDTH   = 25,
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_PORTS       = 4,
  parameter int GRANT_HOLD      = 32,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address_i,
  input  logic [NUM_PORTS-1:0]               req_valid_i,
  output logic [NUM_PORTS-1:0]               req_full_o,
  output logic [DATA_WIDTH-1:0]              rsp_data_o,
  output logic [NUM_PORTS-1:0]               rsp_valid_o,
  output logic [ADDRESS_WIDTH-1:0]           mem_address_o,
  output logic                               mem_rd_o,
  input  logic                               mem_full_i,
  input  logic [DATA_WIDTH-1:0]              mem_data_i,
  input  logic                               mem_data_valid_i,
  output logic [$clog2(NUM_PORTS)-1:0]       grant_id_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_underflow_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int HW = $clog2(GRANT_HOLD + 1);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [OW-1:0] FULL_COUNT = OW'(MAX_OUTSTANDING);
  localparam logic [HW-1:0] LAST_HOLD  = HW'(GRANT_HOLD - 1);
  localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS - 1);
  localparam logic [QW-1:0] LAST_SLOT  = QW'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  arb_state_t               state_q, state_d;
  logic [PW-1:0]            grant_q, grant_d;
  logic [PW-1:0]            last_q, last_d;
  logic [HW-1:0]            hold_q, hold_d;

  logic [PW-1:0]            tag_mem [MAX_OUTSTANDING];
  logic [QW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]            count_q, count_d;

  logic [NUM_PORTS-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                     err_q, err_d;

  logic [ADDRESS_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [PW-1:0]            rr_sel;
  logic                     rr_found;
  logic                     can_issue;
  logic                     granted_valid;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     underflow;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_addr_unpack
      assign port_addr[gi] = req_address_i[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    end
  endgenerate

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
    return PW'((int'(base) + k) % NUM_PORTS);
  endfunction

  function automatic logic [QW-1:0] next_ptr(input logic [QW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Search starts just past the last released port so every requester gets a turn.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!rr_found && req_valid_i[rr_index(last_q, k)]) begin
        rr_found = 1'b1;
        rr_sel   = rr_index(last_q, k);
      end
    end
  end

  assign can_issue     = !mem_full_i && (count_q != FULL_COUNT);
  assign granted_valid = req_valid_i[grant_q];
  assign accept        = (state_q == ARB_GRANT) && granted_valid && can_issue;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    hold_d     = hold_q;
    req_full_o = '1;
    case (state_q)
      ARB_IDLE: begin
        if (rr_found) begin
          grant_d = rr_sel;
          hold_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        req_full_o[grant_q] = !can_issue;
        if (accept) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == LAST_HOLD) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
          end
        end else if (!granted_valid && can_issue) begin
          // A stalled port keeps its grant; only a voluntary drop releases it.
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign push      = accept;
  assign pop       = mem_data_valid_i && (count_q != '0);
  assign underflow = mem_data_valid_i && (count_q == '0);

  always_comb begin
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q | underflow;
    if (pop) begin
      rsp_valid_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << tag_mem[rd_ptr_q];
      rsp_data_d  = mem_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= grant_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      last_q      <= LAST_PORT;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign mem_rd_o        = accept;
  assign mem_address_o   = port_addr[grant_q];
  assign grant_id_o      = grant_q;
  assign outstanding_o   = count_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign err_underflow_o = err_q;

endmodule
`default_nettype wire
